// File: rtl/timer_irq_if.sv
// Word-addressed register bus between the CPU data-memory port and timer_irq.
interface timer_irq_if;
    logic [1:0]  addr;
    logic        wen;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output addr, output wen, output din, input dout);
    modport slave  (input addr, input wen, input din, output dout);
endinterface

// File: rtl/timer_irq.sv
// Programmable down-counting timer with a sticky level interrupt for CP0 HWInt[0].
// Define TIMER_PRESCALE_EN to add the PRESCALE register at addr 3.
module timer_irq #(
    parameter int CNT_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    timer_irq_if.slave bus,
    output logic       irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic             en_q, en_d;
    logic [1:0]       mode_q, mode_d;
    logic             im_q, im_d;
    logic [CNT_W-1:0] preset_q, preset_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flag_q, flag_d;
    logic             tick;
    logic             ctrl_wr;
    logic             preset_wr;

    assign ctrl_wr   = bus.wen && (bus.addr == 2'd0);
    assign preset_wr = bus.wen && (bus.addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pre_cnt_q, pre_cnt_d;
    logic        prescale_wr;

    assign prescale_wr = bus.wen && (bus.addr == 2'd3);
    // >= rather than == so a PRESCALE lowered mid-count cannot strand the counter
    assign tick = (pre_cnt_q >= prescale_q);
`else
    assign tick = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            mode_q   <= 2'b00;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            flag_q   <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            prescale_q <= '0;
            pre_cnt_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
`ifdef TIMER_PRESCALE_EN
            prescale_q <= prescale_d;
            pre_cnt_q  <= pre_cnt_d;
`endif
        end
    end

    // Bus writes are applied first so the FSM's flag set below overrides an ack on the same edge.
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        flag_d   = flag_q;
`ifdef TIMER_PRESCALE_EN
        prescale_d = prescale_q;
        pre_cnt_d  = pre_cnt_q;
        if (prescale_wr) begin
            prescale_d = bus.din[15:0];
        end
`endif

        if (ctrl_wr) begin
            en_d   = bus.din[0];
            mode_d = bus.din[2:1];
            im_d   = bus.din[3];
            flag_d = 1'b0;
        end
        if (preset_wr) begin
            preset_d = bus.din[CNT_W-1:0];
        end

        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
`ifdef TIMER_PRESCALE_EN
                pre_cnt_d = '0;
`endif
                state_d = CNT;
            end
            CNT: begin
                if (!en_q) begin
                    state_d = IDLE;
                end else begin
`ifdef TIMER_PRESCALE_EN
                    pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
`endif
                    if (tick) begin
                        if (count_q > CNT_ONE) begin
                            count_d = count_q - CNT_ONE;
                        end else begin
                            count_d = '0;
                            flag_d  = 1'b1;
                            state_d = INT;
                        end
                    end
                end
            end
            INT: begin
                if (mode_q == 2'b01) begin
                    state_d = LOAD;
                end else begin
                    // A simultaneous software CTRL write decides EN instead of the auto-clear
                    if (!ctrl_wr) begin
                        en_d = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        bus.dout = '0;
        case (bus.addr)
            2'd0: bus.dout = {28'd0, im_q, mode_q, en_q};
            2'd1: bus.dout = 32'(preset_q);
            2'd2: bus.dout = 32'(count_q);
`ifdef TIMER_PRESCALE_EN
            2'd3: bus.dout = 32'(prescale_q);
`else
            2'd3: bus.dout = '0;
`endif
            default: bus.dout = '0;
        endcase
    end

    assign irq = flag_q & im_q;

endmodule

// File: tb/tb_timer_irq.sv
// Self-checking bench for timer_irq: vector table, directed corner sequences,
// and randomized runs against an arithmetic timing model.
module tb_timer_irq;

    logic clk = 1'b0;
    logic rst_n;
    logic irq;

    timer_irq_if bus();

    timer_irq #(.CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[12];
    int checks = 0;
    int passed = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        bus.addr = a;
        bus.din  = d;
        bus.wen  = 1'b1;
        @(posedge clk);
        #1;
        bus.wen  = 1'b0;
    endtask

    task automatic readReg(input logic [1:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.dout;
    endtask

    task automatic expectReg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        readReg(a, d);
        checkOutput(name, d, exp);
    endtask

    task automatic applyStimulus(input vec_t v);
        if (v.wr) busWrite(v.waddr, v.wdata);
        else      stepCycle();
    endtask

    task automatic doReset();
        bus.wen = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        stepCycle();
    endtask

    function automatic int clampZero(input int v);
        return (v < 0) ? 0 : v;
    endfunction

    // Expected state j edges after the enabling CTRL write, derived from the
    // documented timing: COUNT=PRESET at j=2, terminal at j=Ne+2, period Ne+2.
    function automatic void modelTimer(input int n, input int mode, input int im, input int j,
                                       output int cnt, output int ctrl, output int irq_e);
        int ne;
        int period;
        bit auto_rl;
        bit en;
        bit flag;
        ne      = (n < 1) ? 1 : n;
        period  = ne + 2;
        auto_rl = (mode == 1);
        flag    = (j >= ne + 2);
        en      = auto_rl ? 1'b1 : (j < ne + 3);
        if (j < 2)        cnt = 0;
        else if (auto_rl) cnt = clampZero(n - ((j - 2) % period));
        else              cnt = clampZero(n - (j - 2));
        ctrl  = (im << 3) | (mode << 1) | int'(en);
        irq_e = int'(flag) & im;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int n, mode, im, cnt_e, ctrl_e, irq_e;

        // One-shot PRESET=5 walk-through, one record per clock edge
        vecs[0]  = '{1'b1, 2'd1, 32'd5,   2'd1, 32'd5,   1'b0};
        vecs[1]  = '{1'b1, 2'd0, 32'h9,   2'd0, 32'h9,   1'b0};
        vecs[2]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd0,   1'b0};
        vecs[3]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd5,   1'b0};
        vecs[4]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd4,   1'b0};
        vecs[5]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd3,   1'b0};
        vecs[6]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd2,   1'b0};
        vecs[7]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd1,   1'b0};
        vecs[8]  = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd0,   1'b1};
        vecs[9]  = '{1'b0, 2'd0, 32'd0,   2'd0, 32'h8,   1'b1};
        vecs[10] = '{1'b1, 2'd0, 32'h8,   2'd0, 32'h8,   1'b0};
        vecs[11] = '{1'b0, 2'd0, 32'd0,   2'd2, 32'd0,   1'b0};

        bus.addr = 2'd0;
        bus.din  = '0;
        bus.wen  = 1'b0;
        rst_n    = 1'b0;
        #7;
        checkOutput("reset_irq", {31'd0, irq}, 32'd0);
        expectReg("reset_ctrl", 2'd0, 32'd0);
        expectReg("reset_preset", 2'd1, 32'd0);
        expectReg("reset_count", 2'd2, 32'd0);
        rst_n = 1'b1;
        stepCycle();

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            readReg(vecs[i].raddr, rd);
            checkOutput($sformatf("vec%0d_dout", i), rd, vecs[i].exp_dout);
            checkOutput($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].exp_irq});
        end

        // Asynchronous reset while the interrupt is pending
        doReset();
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h9);
        for (int i = 0; i < 10 && !irq; i++) stepCycle();
        checkOutput("rst_pre_irq", {31'd0, irq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_irq", {31'd0, irq}, 32'd0);
        expectReg("rst_async_ctrl", 2'd0, 32'd0);
        expectReg("rst_async_preset", 2'd1, 32'd0);
        expectReg("rst_async_count", 2'd2, 32'd0);
        rst_n = 1'b1;
        stepCycle();

        // Auto-reload PRESET=3 with an ack after every interrupt
        doReset();
        busWrite(2'd1, 32'd3);
        busWrite(2'd0, 32'hB);
        for (int c = 1; c <= 16; c++) begin
            if (irq) busWrite(2'd0, 32'hB);
            else     stepCycle();
            checkOutput($sformatf("ar_irq_c%0d", c), {31'd0, irq}, (c % 5 == 0) ? 32'd1 : 32'd0);
            if (c % 5 == 2) expectReg($sformatf("ar_reload_c%0d", c), 2'd2, 32'd3);
        end

        // Masked terminal count, then IM=1 written on the next flag-set edge
        doReset();
        busWrite(2'd1, 32'd3);
        busWrite(2'd0, 32'h3);
        for (int c = 1; c <= 9; c++) begin
            stepCycle();
            checkOutput($sformatf("mask_irq_c%0d", c), {31'd0, irq}, 32'd0);
        end
        busWrite(2'd0, 32'hB);
        checkOutput("mask_reexpose", {31'd0, irq}, 32'd1);
        stepCycle();
        checkOutput("mask_held", {31'd0, irq}, 32'd1);

        // One-shot collisions: ack on the set edge, then EN write on the INT edge
        doReset();
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h9);
        for (int c = 1; c <= 3; c++) stepCycle();
        busWrite(2'd0, 32'h9);
        checkOutput("coll_set_wins", {31'd0, irq}, 32'd1);
        busWrite(2'd0, 32'h9);
        expectReg("coll_en_wins", 2'd0, 32'h9);
        checkOutput("coll_ack", {31'd0, irq}, 32'd0);
        stepCycle();
        stepCycle();
        expectReg("coll_reload", 2'd2, 32'd2);

        // Pause at COUNT=7, resume through LOAD, PRESET write mid-count
        doReset();
        busWrite(2'd1, 32'd10);
        busWrite(2'd0, 32'h9);
        for (int c = 1; c <= 4; c++) stepCycle();
        expectReg("pause_pre", 2'd2, 32'd8);
        busWrite(2'd0, 32'h8);
        expectReg("pause_at7", 2'd2, 32'd7);
        for (int c = 1; c <= 3; c++) begin
            stepCycle();
            expectReg($sformatf("pause_hold%0d", c), 2'd2, 32'd7);
        end
        expectReg("pause_ctrl", 2'd0, 32'h8);
        busWrite(2'd0, 32'h9);
        expectReg("resume_m0", 2'd2, 32'd7);
        stepCycle();
        expectReg("resume_m1", 2'd2, 32'd7);
        stepCycle();
        expectReg("resume_load", 2'd2, 32'd10);
        busWrite(2'd1, 32'd4);
        expectReg("preset_wr_cnt", 2'd2, 32'd9);
        stepCycle();
        expectReg("preset_wr_cnt2", 2'd2, 32'd8);
        expectReg("preset_wr_val", 2'd1, 32'd4);

        // PRESET=0 fires like PRESET=1
        doReset();
        busWrite(2'd1, 32'd0);
        busWrite(2'd0, 32'h9);
        stepCycle();
        checkOutput("p0_irq_k1", {31'd0, irq}, 32'd0);
        stepCycle();
        checkOutput("p0_irq_k2", {31'd0, irq}, 32'd0);
        stepCycle();
        checkOutput("p0_irq_k3", {31'd1, irq} & 32'd1, 32'd1);

`ifdef TIMER_PRESCALE_EN
        doReset();
        busWrite(2'd3, 32'd2);
        expectReg("ps_reg", 2'd3, 32'd2);
        busWrite(2'd1, 32'd2);
        busWrite(2'd0, 32'h9);
        stepCycle();
        for (int c = 0; c <= 6; c++) begin
            stepCycle();
            expectReg($sformatf("ps_cnt_%0d", c), 2'd2, (c < 3) ? 32'd2 : (c < 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("ps_irq_%0d", c), {31'd0, irq}, (c == 6) ? 32'd1 : 32'd0);
        end
`else
        busWrite(2'd3, 32'd5);
        expectReg("addr3_zero", 2'd3, 32'd0);
`endif

        // Randomized runs against the arithmetic model
        for (int t = 0; t < 10; t++) begin
            n    = $urandom_range(0, 12);
            mode = $urandom_range(0, 3);
            im   = $urandom_range(0, 1);
            doReset();
            busWrite(2'd1, n);
            busWrite(2'd0, (im << 3) | (mode << 1) | 1);
            for (int j = 0; j <= 2 * ((n < 1 ? 1 : n) + 2) + 3; j++) begin
                if (j > 0) stepCycle();
                modelTimer(n, mode, im, j, cnt_e, ctrl_e, irq_e);
                expectReg($sformatf("rnd%0d_j%0d_count", t, j), 2'd2, cnt_e);
                expectReg($sformatf("rnd%0d_j%0d_ctrl", t, j), 2'd0, ctrl_e);
                checkOutput($sformatf("rnd%0d_j%0d_irq", t, j), {31'd0, irq}, irq_e);
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/timer_irq.md
# timer_irq

Programmable down-counting timer that drives one hardware interrupt line into the CP0 `HWInt[5:0]` input, normally bit 0, which is the line CP0 enables after reset. The CPU programs it over the data-memory bus with word-addressed register reads and writes. It counts down from a preset value and raises a level interrupt at terminal count. The interrupt holds until software acknowledges it, so CP0 sees a stable request until its handler runs.

## Interface
- `CNT_W`, default 32: width of the PRESET and COUNT registers; values are zero-extended to 32 bits on read.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `addr`  in  2: register select; this is CPU byte address bits [3:2].
- `wen`  in  1: write strobe; it is sampled on the rising edge of `clk`.
- `din`  in  32: write data.
- `dout`  out  32: combinational read data for the register selected by `addr`.
- `irq`  out  1: interrupt request, wired to `HWInt[0]`; it is `irq_flag & CTRL.IM`.

## Operation
- Register map:
  - 0 = CTRL. Bit [0] is EN. Bits [2:1] are MODE: 00 one-shot, 01 auto-reload, 10/11 behave as 00. Bit [3] is IM. Other bits read 0.
  - 1 = PRESET, read/write.
  - 2 = COUNT. Read-only; writes are ignored.
  - 3 = PRESCALE when `TIMER_PRESCALE_EN` is defined, otherwise reads 0 and ignores writes.
- Reset values: all registers 0, `irq_flag` 0, FSM in IDLE, `irq` 0, `dout` reflects the zeroed registers.
- FSM states and transitions:
  - IDLE: move to LOAD when EN=1.
  - LOAD: COUNT <= PRESET; clear the prescale counter; move to CNT.
  - CNT, EN=0: move to IDLE; COUNT holds its value.
  - CNT, EN=1 and tick and COUNT>1: COUNT <= COUNT-1.
  - CNT, EN=1 and tick and COUNT<=1: COUNT <= 0, `irq_flag` <= 1, move to INT.
  - INT, MODE=01: move to LOAD.
  - INT, otherwise: clear EN and move to IDLE.
- PRESET=0 behaves the same as PRESET=1.
- Interrupt acknowledge: any bus write to CTRL clears `irq_flag`.
- Boundary and collision rules:
  - Setting `irq_flag` and a CTRL write on the same edge: the set wins, so no interrupt is lost.
  - INT clearing EN and a bus write to CTRL on the same edge: the bus write's EN value wins.
  - Writing PRESET while counting does not change COUNT until the next LOAD.
  - Clearing EN while counting freezes COUNT. Setting EN again passes through LOAD, which reloads COUNT.
  - Writing IM=0 masks `irq` but keeps `irq_flag`. Setting IM=1 again re-exposes a pending interrupt.
  - `rst_n` asserted mid-count returns the block to its reset values immediately, without waiting for a clock edge.

## Timing
- Read latency is 0 cycles, because `dout` is combinational. Write latency is 1 edge.
- Reference point: CTRL.EN is written at edge k.
  - Edge k+1: IDLE→LOAD.
  - Edge k+2: COUNT=PRESET=N.
  - Edges k+3 onward: one decrement per tick.
  - Edge k+N+2: COUNT=0 and `irq` rises (N≥1, IM=1, no prescale).
- Auto-reload period: N+2 cycles between successive `irq_flag` sets, covering the INT and LOAD cycles.
- `irq` is a registered level; it has no combinational path from the bus.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - PRESCALE (16 bits, reset 0) is implemented at addr 3.
  - An internal prescale counter counts 0..PRESCALE and produces a tick when it equals PRESCALE, then wraps to 0.
  - COUNT therefore decrements once every PRESCALE+1 cycles. PRESCALE=0 is identical to the undefined case.
- `TIMER_PRESCALE_EN` undefined:
  - A tick is produced every cycle.
  - No prescale logic is synthesized.
  - Addr 3 reads 0 and ignores writes.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle → `irq`=0, and CTRL/PRESET/COUNT read 0 immediately.
- One-shot: PRESET=5, CTRL=0x9 (EN, IM, MODE 00) at edge k → COUNT reads 5,4,3,2,1 on successive cycles, `irq`=1 after edge k+7, CTRL reads 0x8, and writing CTRL=0x8 drops `irq` on the next edge.
- Auto-reload: PRESET=3, CTRL=0xB → `irq_flag` is set every 5 cycles. Acknowledge each time and check that COUNT reloads to 3 in LOAD.
- Mask and collision:
  - IM=0 at terminal count → `irq`=0 while the flag is held; then set IM=1 → `irq`=1.
  - A CTRL write on the same edge as the flag set → `irq` stays 1.
- Pause and preset edge cases:
  - Clear EN at COUNT=7 → COUNT stays 7; re-enable → COUNT restarts from PRESET.
  - PRESET=0 → `irq` after edge k+3.
- With `TIMER_PRESCALE_EN`: PRESCALE=2, PRESET=2 → each COUNT value holds for 3 cycles, and `irq` rises 3 cycles after COUNT reads 1.
